// File: rtl/mii_pkg.sv
// Shared MII MAC definitions (RX and TX): framing nibbles, CRC-32 constants,
// receive state encoding and the registered output bundle of the RX MAC.
package mii_pkg;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hd;
  localparam logic [31:0] CRC_INIT     = 32'hffffffff;
  localparam logic [31:0] CRC_POLY     = 32'h04c11db7;
  localparam logic [31:0] CRC_RESIDUE  = 32'hdebb20e3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       err;
    logic       ok;
    logic       fcs_error;
    logic       too_short;
    logic       too_long;
    logic       rx_error;
  } rx_out_t;

endpackage

// File: rtl/axis_mii_rx_if.sv
// Beat-per-byte receive stream. There is no ready: the slave must take every
// beat on which axis_valid is high.
interface axis_mii_rx_if;
  logic [7:0] axis_data;
  logic       axis_valid;
  logic       axis_last;
  logic       axis_err;

  modport master (output axis_data, axis_valid, axis_last, axis_err);
  modport slave  (input  axis_data, axis_valid, axis_last, axis_err);
endinterface

// File: rtl/lfsr.sv
// Combinational Galois LFSR step: advances state_in by DATA_WIDTH data bits.
// REVERSE selects the reflected (LSB-first) form used by the Ethernet FCS.
module lfsr #(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
    for (int i = 0; i < LFSR_WIDTH; i++) bit_rev[i] = v[LFSR_WIDTH-1-i];
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = bit_rev(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] s;

  always_comb begin
    // NOTE: blocking assignments here; s is a temporary rebuilt once per data bit.
    s = state_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        if (s[0] ^ data_in[i]) s = (s >> 1) ^ POLY_REV;
        else                   s = s >> 1;
      end else begin
        if (s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i]) s = (s << 1) ^ LFSR_POLY;
        else                                            s = s << 1;
      end
    end
    state_out = s;
  end

endmodule

// File: rtl/axis_mii_rx.sv
// 100M MII receive MAC: preamble/SFD strip, nibble->byte, FCS and length check,
// non-stallable beat-per-byte stream. Define AXIS_MII_RX_STRIP_FCS_EN to drop the FCS bytes.
module axis_mii_rx
  import mii_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mii_rx_ce,
  input  logic                 mii_rx_dv,
  input  logic [3:0]           mii_rxd,
  input  logic                 mii_rx_er,
  axis_mii_rx_if.master        axis,
  output logic                 frame_ok,
  output logic                 fcs_error,
  output logic                 frame_too_short,
  output logic                 frame_too_long,
  output logic                 rx_error
);

`ifdef AXIS_MII_RX_STRIP_FCS_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif
  localparam int          HW       = 8 * D;
  localparam int          BW       = $clog2(D + 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] OVER_CNT = 11'(MAX_FRAME_BYTES + 1);

  rx_state_e         state_q, state_d;
  logic              nib_phase_q, nib_phase_d;
  logic [3:0]        low_nib_q, low_nib_d;
  logic [31:0]       crc_q, crc_d, crc_next;
  logic [10:0]       count_q, count_d, count_inc;
  logic              er_seen_q, er_seen_d;
  logic [HW-1:0]     hold_q, hold_d;   // byte 0 (bits 7:0) is the oldest
  logic [BW-1:0]     hold_cnt_q, hold_cnt_d;
  rx_out_t           out_q, out_d;
  logic [7:0]        new_byte;
  logic              in_data, sfd_hit, hold_full, byte_done;

  assign in_data   = mii_rx_ce && (state_q == ST_DATA);
  assign sfd_hit   = mii_rx_ce && (state_q == ST_PREAMBLE) && mii_rx_dv &&
                     !mii_rx_er && (mii_rxd == SFD_NIB);
  assign byte_done = in_data && mii_rx_dv && nib_phase_q;
  assign new_byte  = {mii_rxd, low_nib_q};
  assign count_inc = count_q + 11'd1;
  assign hold_full = (hold_cnt_q == BW'(D));

  lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC_POLY),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .state_in  (crc_q),
    .data_in   (new_byte),
    .state_out (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mii_rx_ce) begin
      unique case (state_q)
        ST_IDLE:     if (mii_rx_dv) state_d = ST_PREAMBLE;
        ST_PREAMBLE: begin
          if (!mii_rx_dv)                 state_d = ST_IDLE;
          else if (mii_rx_er)             state_d = ST_DROP;
          else if (mii_rxd == SFD_NIB)    state_d = ST_DATA;
          else if (mii_rxd != PREAMBLE_NIB) state_d = ST_DROP;
        end
        ST_DATA: begin
          if (!mii_rx_dv)                             state_d = ST_IDLE;
          else if (byte_done && count_inc == OVER_CNT) state_d = ST_DROP;
        end
        ST_DROP:     if (!mii_rx_dv) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    nib_phase_d = nib_phase_q;
    low_nib_d   = low_nib_q;
    crc_d       = crc_q;
    count_d     = count_q;
    er_seen_d   = er_seen_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    out_d       = '0;

    if (sfd_hit) begin
      nib_phase_d = 1'b0;
      crc_d       = CRC_INIT;
      count_d     = '0;
      er_seen_d   = 1'b0;
      hold_cnt_d  = '0;
    end else if (in_data && mii_rx_dv) begin
      if (mii_rx_er) er_seen_d = 1'b1;
      if (!nib_phase_q) begin
        low_nib_d   = mii_rxd;
        nib_phase_d = 1'b1;
      end else begin
        nib_phase_d = 1'b0;
        crc_d       = crc_next;
        count_d     = count_inc;
        if (count_inc == OVER_CNT) begin
          // Truncate: close the frame on the oldest held byte, skip the FCS verdict.
          out_d.data     = hold_q[7:0];
          out_d.valid    = 1'b1;
          out_d.last     = 1'b1;
          out_d.err      = 1'b1;
          out_d.too_long = 1'b1;
          hold_cnt_d     = '0;
        end else begin
          if (hold_full) begin
            out_d.data  = hold_q[7:0];
            out_d.valid = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + BW'(1);
          end
          hold_d = (hold_q >> 8) | (HW'(new_byte) << (8 * (D - 1)));
        end
      end
    end else if (in_data) begin
      // dv fell: close on the oldest byte; anything younger is FCS and is dropped.
      out_d.valid     = 1'b1;
      out_d.last      = 1'b1;
      out_d.data      = hold_full ? hold_q[7:0] : 8'h00;
      out_d.fcs_error = (crc_q != CRC_RESIDUE);
      out_d.too_short = (count_q < MIN_CNT) || !hold_full;
      out_d.rx_error  = er_seen_q || nib_phase_q;
      out_d.err       = out_d.fcs_error || out_d.too_short || out_d.rx_error;
      out_d.ok        = !out_d.err;
      hold_cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_phase_q <= 1'b0;
      low_nib_q   <= '0;
      crc_q       <= CRC_INIT;
      count_q     <= '0;
      er_seen_q   <= 1'b0;
      // NOTE: the holding buffer data is reset as well; it is tiny and keeps outputs deterministic.
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      out_q       <= '0;
    end else begin
      nib_phase_q <= nib_phase_d;
      low_nib_q   <= low_nib_d;
      crc_q       <= crc_d;
      count_q     <= count_d;
      er_seen_q   <= er_seen_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      out_q       <= out_d;
    end
  end

  assign axis.axis_data  = out_q.data;
  assign axis.axis_valid = out_q.valid;
  assign axis.axis_last  = out_q.last;
  assign axis.axis_err   = out_q.err;
  assign frame_ok        = out_q.ok;
  assign fcs_error       = out_q.fcs_error;
  assign frame_too_short = out_q.too_short;
  assign frame_too_long  = out_q.too_long;
  assign rx_error        = out_q.rx_error;

endmodule

// File: tb/tb_axis_mii_rx.sv
// Directed bench for axis_mii_rx: table of frames plus reset and preamble corner cases.
// Works in both builds (AXIS_MII_RX_STRIP_FCS_EN defined or not).
module tb_axis_mii_rx;

`ifdef AXIS_MII_RX_STRIP_FCS_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif
  localparam int MAX_B = 1518;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mii_rx_ce = 1'b0;
  logic       mii_rx_dv = 1'b0;
  logic [3:0] mii_rxd = 4'h0;
  logic       mii_rx_er = 1'b0;
  logic       frame_ok, fcs_error, frame_too_short, frame_too_long, rx_error;

  axis_mii_rx_if axis_if();

  axis_mii_rx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mii_rx_ce       (mii_rx_ce),
    .mii_rx_dv       (mii_rx_dv),
    .mii_rxd         (mii_rxd),
    .mii_rx_er       (mii_rx_er),
    .axis            (axis_if),
    .frame_ok        (frame_ok),
    .fcs_error       (fcs_error),
    .frame_too_short (frame_too_short),
    .frame_too_long  (frame_too_long),
    .rx_error        (rx_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
    logic       ok;
    logic       fcs;
    logic       shrt;
    logic       lng;
    logic       rxe;
  } beat_t;

  typedef struct {
    string name;
    int    len;
    int    seed;
    int    flip;      // byte index to corrupt after FCS is computed, -1 none
    int    er_byte;   // 1-based byte carrying rx_er, 0 none
    int    odd;       // append a dribble nibble
    int    bad_pre;   // put nibble 3 in the preamble
    int    exp_beats;
    int    exp_idx;   // frame byte expected on the last beat, -1 means 8'h00
    int    e_err;
    int    e_ok;
    int    e_fcs;
    int    fcs_dc;    // fcs_error not checked
    int    e_short;
    int    e_long;
    int    e_rxe;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         stray   = 0;
  beat_t      cap_q[$];
  logic [7:0] frame_q[$];
  vec_t       vecs[9];
  logic [15:0] out_vec;

  assign out_vec = {axis_if.axis_data, axis_if.axis_valid, axis_if.axis_last, axis_if.axis_err,
                    frame_ok, fcs_error, frame_too_short, frame_too_long, rx_error};

  always @(negedge clk) begin
    beat_t b;
    if (axis_if.axis_valid) begin
      b.data = axis_if.axis_data;
      b.last = axis_if.axis_last;
      b.err  = axis_if.axis_err;
      b.ok   = frame_ok;
      b.fcs  = fcs_error;
      b.shrt = frame_too_short;
      b.lng  = frame_too_long;
      b.rxe  = rx_error;
      cap_q.push_back(b);
    end
    if ((frame_ok || fcs_error || frame_too_short || frame_too_long || rx_error) &&
        !(axis_if.axis_valid && axis_if.axis_last))
      stray++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected bench to complete");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_nib(input logic dv, input logic [3:0] d, input logic er);
    @(negedge clk);
    mii_rx_dv = dv;
    mii_rxd   = d;
    mii_rx_er = er;
    mii_rx_ce = 1'b1;
    @(negedge clk);
    mii_rx_ce = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Payload pattern plus textbook Ethernet FCS (reflected CRC-32, final invert, LSB byte first).
  task automatic build_frame(input int len, input int seed, input int flip);
    logic [31:0] crc;
    frame_q.delete();
    if (len < 4) begin
      for (int i = 0; i < len; i++) frame_q.push_back(8'(i * 37 + seed));
    end else begin
      for (int i = 0; i < len - 4; i++) frame_q.push_back(8'(i * 37 + seed));
      crc = 32'hffffffff;
      foreach (frame_q[i]) begin
        crc = crc ^ {24'h0, frame_q[i]};
        for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hedb88320) : (crc >> 1);
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) frame_q.push_back(crc[8*k +: 8]);
    end
    if (flip >= 0) frame_q[flip] = frame_q[flip] ^ 8'h04;
  endtask

  task automatic send_frame(input int er_byte, input int odd, input int bad_pre, input int abort_after);
    for (int i = 0; i < 15; i++) drive_nib(1'b1, (bad_pre != 0 && i == 6) ? 4'h3 : 4'h5, 1'b0);
    drive_nib(1'b1, 4'hd, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (abort_after > 0 && i == abort_after) return;
      drive_nib(1'b1, frame_q[i][3:0], 1'b0);
      drive_nib(1'b1, frame_q[i][7:4], (i + 1) == er_byte);
    end
    if (odd != 0) drive_nib(1'b1, 4'ha, 1'b0);
    repeat (4) drive_nib(1'b0, 4'h0, 1'b0);
  endtask

  task automatic eval_frame(input vec_t v, input int start);
    int    n, body_bad, exp_data;
    beat_t lb;
    n = cap_q.size() - start;
    check({v.name, ".beats"}, n, v.exp_beats);
    if (n > 0) begin
      body_bad = 0;
      for (int i = 0; i < n - 1; i++)
        if (cap_q[start+i].last || cap_q[start+i].data != frame_q[i]) body_bad++;
      lb = cap_q[start+n-1];
      exp_data = 0;
      if (v.exp_idx >= 0) exp_data = int'(frame_q[v.exp_idx]);
      check({v.name, ".body"},  body_bad, 0);
      check({v.name, ".last"},  int'(lb.last), 1);
      check({v.name, ".ldata"}, int'(lb.data), exp_data);
      check({v.name, ".err"},   int'(lb.err),  v.e_err);
      check({v.name, ".ok"},    int'(lb.ok),   v.e_ok);
      if (v.fcs_dc == 0) check({v.name, ".fcs"}, int'(lb.fcs), v.e_fcs);
      check({v.name, ".short"}, int'(lb.shrt), v.e_short);
      check({v.name, ".long"},  int'(lb.lng),  v.e_long);
      check({v.name, ".rxerr"}, int'(lb.rxe),  v.e_rxe);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    build_frame(v.len, v.seed, v.flip);
    start = cap_q.size();
    send_frame(v.er_byte, v.odd, v.bad_pre, 0);
    eval_frame(v, start);
  endtask

  initial begin
    int start, lasts;

    //            name       len  seed flip er odd bad beats                 idx                  err ok fcs dc sh lg rxe
    vecs[0] = '{"good64",    64,  1,   -1,  0, 0,  0,  64 - D + 1,           64 - D,              0,  1, 0,  0, 0, 0, 0};
    vecs[1] = '{"flip64",    64,  1,   10,  0, 0,  0,  64 - D + 1,           64 - D,              1,  0, 1,  0, 0, 0, 0};
    vecs[2] = '{"short20",   20,  3,   -1,  0, 0,  0,  20 - D + 1,           20 - D,              1,  0, 0,  0, 1, 0, 0};
    vecs[3] = '{"tiny3",     3,   7,   -1,  0, 0,  0,  (3 < D) ? 1 : 4 - D,  (3 < D) ? -1 : 3 - D, 1, 0, 0,  1, 1, 0, 0};
    vecs[4] = '{"long1600",  1600, 2,  -1,  0, 0,  0,  MAX_B - D + 1,        MAX_B - D,           1,  0, 0,  0, 0, 1, 0};
    vecs[5] = '{"rxer30",    64,  4,   -1,  30, 0, 0,  64 - D + 1,           64 - D,              1,  0, 0,  0, 0, 0, 1};
    vecs[6] = '{"dribble",   64,  6,   -1,  0, 1,  0,  64 - D + 1,           64 - D,              1,  0, 0,  0, 0, 0, 1};
    vecs[7] = '{"badpre",    64,  8,   -1,  0, 0,  1,  0,                    0,                   0,  0, 0,  0, 0, 0, 0};
    vecs[8] = '{"good100",   100, 5,   -1,  0, 0,  0,  100 - D + 1,          100 - D,             0,  1, 0,  0, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("reset.outputs", int'(out_vec), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle.outputs", int'(out_vec), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a frame, then a clean frame must follow.
    build_frame(64, 9, -1);
    start = cap_q.size();
    send_frame(0, 0, 0, 30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs", int'(out_vec), 0);
    check("rst_mid.beats", cap_q.size() - start, 30 - D);
    lasts = 0;
    for (int i = start; i < cap_q.size(); i++) if (cap_q[i].last) lasts++;
    check("rst_mid.nolast", lasts, 0);
    mii_rx_dv = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_hold.outputs", int'(out_vec), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_vec(vecs[0]);

    check("stray_pulses", stray, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
